pifo_drain_checker: RTL

PIFO_DRAIN_CHECKER -- requirements
Module: pifo_drain_checker

---
 rtl/pifo_drain_checker_pkg.sv | 46 ++++
 rtl/pifo_drain_checker_lfsr.sv | 31 +++
 rtl/pifo_drain_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pifo_drain_checker_pkg.sv
// pifo_drain_checker_pkg: shared types for the PIFO drain checker and its bench.
// Holds the packet/priority/rate/counter types, the checker configuration
// struct, the drain FSM state enum and the LFSR tap table.
package pifo_drain_checker_pkg;

    typedef logic [15:0] PacketPointer;
    typedef logic [7:0]  Priority;
    typedef logic [7:0]  InjectionRate;
    typedef logic [15:0] CounterSignal;

    // Held static by the test controller while the checker is out of IDLE.
    typedef struct packed {
        InjectionRate deqrate;          // dequeue when lfsr < deqrate
        InjectionRate deqrate_seed;     // LFSR value loaded on reset
        CounterSignal expected_packets; // packets to drain before DONE
    } DCConfig;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        STALL = 2'd3
    } DrainState;

    // Maximal-length Galois (right-shift) feedback masks for 2..16 bits.
    function automatic logic [31:0] lfsr_taps(input int num_bits);
        case (num_bits)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            default: return 32'h0000_D008;
        endcase
    endfunction

endpackage

// File: rtl/pifo_drain_checker_lfsr.sv
// linear_feedback_shift_register: Galois LFSR used to randomise the dequeue
// rate. Loads i_seed on reset and steps once per cycle while i_advance is high.
// An all-zero seed is a lock-up state and holds at zero.
module linear_feedback_shift_register
    import pifo_drain_checker_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] i_seed,
    input  logic                i_advance,
    output logic [NUM_BITS-1:0] o_value
);

    localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(lfsr_taps(NUM_BITS));

    logic [NUM_BITS-1:0] r_q;

    // Seed on reset, otherwise shift right and fold the feedback mask in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= i_seed;
        end else if (i_advance) begin
            r_q <= {1'b0, r_q[NUM_BITS-1:1]} ^ (r_q[0] ? TAPS : '0);
        end
    end

    assign o_value = r_q;

endmodule

// File: rtl/pifo_drain_checker.sv
// pifo_drain_checker: drains a PIFO at an LFSR-gated rate, counts popped
// packets, flags priority-order violations and detects drain stalls.
// Optional macro PIFO_DRAIN_CHECKER_ERRLOG_EN adds capture of the first
// violating packet's pointer and priority on o__err_pointer/o__err_priority.
//
// PIFO handshake: i__pifo_valid is the valid, o__pifo_dequeue is the ready.
// A pop happens in exactly the cycle both are high, and the head consumed is
// the pointer/priority presented in that same cycle. o__pifo_dequeue never
// depends on itself and is forced low while reset is high.
module pifo_drain_checker
    import pifo_drain_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  DCConfig      i__config,
    input  logic         i__drain_phase,
    input  logic         i__pifo_valid,
    input  PacketPointer i__pifo_packet_pointer,
    input  Priority      i__pifo_priority,
    output logic         o__pifo_dequeue,
    output CounterSignal o__num_pkts_received,
    output CounterSignal o__order_errors,
    output DrainState    o__state,
    output PacketPointer o__err_pointer,
    output Priority      o__err_priority
);

    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

    DrainState          r_state;
    CounterSignal       r_received;
    CounterSignal       r_order_errors;
    Priority            r_last_prio;
    logic               r_first;
    logic [STALL_W-1:0] r_stall_cnt;

    InjectionRate       w_lfsr;
    logic               w_in_drain;
    logic               w_drain_active;
    logic               w_dequeue;
    logic               w_violation;
    CounterSignal       w_received_inc;
    logic               w_done_hit;
    logic [STALL_W-1:0] w_stall_next;
    logic               w_stall_hit;

    assign w_in_drain     = (r_state == DRAIN);
    assign w_drain_active = w_in_drain && i__drain_phase;

    linear_feedback_shift_register #(
        .NUM_BITS ($bits(InjectionRate))
    ) u_rate_lfsr (
        .clk       (clk),
        .reset     (reset),
        .i_seed    (i__config.deqrate_seed),
        .i_advance (w_drain_active),
        .o_value   (w_lfsr)
    );

    assign w_dequeue = !reset && w_drain_active && i__pifo_valid
                     && (w_lfsr < i__config.deqrate)
                     && (r_received < i__config.expected_packets);

    // Equal priorities are legal; the first pop after reset has no reference.
    assign w_violation = w_dequeue && !r_first && (i__pifo_priority < r_last_prio);

    assign w_received_inc = r_received + CounterSignal'(1);

    // Already complete (covers expected_packets == 0) or this pop completes it.
    assign w_done_hit = (r_received == i__config.expected_packets)
                     || (w_dequeue && (w_received_inc == i__config.expected_packets));

    // Next stall count: cleared by a pop, bumped on every idle DRAIN cycle.
    always_comb begin
        w_stall_next = r_stall_cnt;
        if (w_in_drain) begin
            if (w_dequeue) begin
                w_stall_next = '0;
            end else if (r_stall_cnt != STALL_LIMIT) begin
                w_stall_next = r_stall_cnt + STALL_W'(1);
            end
        end
    end

    assign w_stall_hit = w_in_drain && (w_stall_next == STALL_LIMIT);

    // Drain FSM; DONE and STALL hold until reset, DONE wins a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i__drain_phase) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_done_hit) begin
                        r_state <= DONE;
                    end else if (w_stall_hit) begin
                        r_state <= STALL;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    // Packet counting, ordering reference, error count and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_received     <= '0;
            r_order_errors <= '0;
            r_last_prio    <= '0;
            r_first        <= 1'b1;
            r_stall_cnt    <= '0;
        end else begin
            if ((r_state == IDLE) && i__drain_phase) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= w_stall_next;
            end
            if (w_dequeue) begin
                r_received  <= w_received_inc;
                r_last_prio <= i__pifo_priority;
                r_first     <= 1'b0;
            end
            if (w_violation && (r_order_errors != '1)) begin
                r_order_errors <= r_order_errors + CounterSignal'(1);
            end
        end
    end

`ifdef PIFO_DRAIN_CHECKER_ERRLOG_EN
    PacketPointer r_err_pointer;
    Priority      r_err_priority;

    // Capture the first violation only; the error count is still zero then.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_pointer  <= '0;
            r_err_priority <= '0;
        end else if (w_violation && (r_order_errors == '0)) begin
            r_err_pointer  <= i__pifo_packet_pointer;
            r_err_priority <= i__pifo_priority;
        end
    end

    assign o__err_pointer  = r_err_pointer;
    assign o__err_priority = r_err_priority;
`else
    // Pointer only matters to the error log; fold it away otherwise.
    logic w_unused_pointer;
    assign w_unused_pointer = ^i__pifo_packet_pointer;

    assign o__err_pointer  = '0;
    assign o__err_priority = '0;
`endif

    assign o__pifo_dequeue      = w_dequeue;
    assign o__num_pkts_received = r_received;
    assign o__order_errors      = r_order_errors;
    assign o__state             = r_state;

endmodule
